// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the load/store front-end: access sizes,
// controller states, the alignment rule and the byte-lane enable pattern.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } state_t;

    // A request is rejected when its size is illegal or it straddles its natural alignment.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << offset;
            SZ_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core-side request/response bus of the load/store front-end.
// The core drives through master; the controller consumes through slave.
interface mem_access_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_signed;
    logic [WIDTH+1:0] req_addr;
    logic [31:0]      req_wdata;
    logic             rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_access_ctrl_byte_lane_unit.sv
// Combinational lane logic: extracts/extends sub-word loads and merges
// sub-word store data into the previously read memory word.
module byte_lane_unit
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_word,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [31:0] w_shifted;
    logic [31:0] w_rep;
    logic [3:0]  w_mask;

    assign w_shifted = i_word >> {i_offset, 3'b000};
    assign w_mask    = lane_mask(i_size, i_offset);

    always_comb begin
        o_load = w_shifted;
        case (i_size)
            SZ_BYTE: o_load = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: o_load = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: o_load = w_shifted;
        endcase
    end

    // Replicating the store data puts it in every lane the mask might select.
    always_comb begin
        w_rep = i_wdata;
        case (i_size)
            SZ_BYTE: w_rep = {4{i_wdata[7:0]}};
            SZ_HALF: w_rep = {2{i_wdata[15:0]}};
            default: w_rep = i_wdata;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign o_merged[8*gi +: 8] = w_mask[gi] ? w_rep[8*gi +: 8] : i_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front-end for a 32-bit word memory with one-cycle registered reads.
// Sub-word stores are done as read-modify-write; every request gets one response pulse.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    mem_access_ctrl_if.slave  bus,
    output logic [WIDTH-1:0]  mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_rw,
    output logic              mem_valid,
    input  logic [31:0]       mem_dout
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_we;
    logic             r_signed;
    logic [1:0]       r_size;
    logic [WIDTH+1:0] r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_din;
    logic [31:0]      r_rsp_rdata;
    logic             r_rsp_err;

    logic             w_bad;
    logic             w_word_store;
    logic             w_idle;
    logic             w_mem_valid;
    logic             w_mem_rw;
    logic             w_rsp_valid;
    logic [31:0]      w_load_data;
    logic [31:0]      w_merged;

    assign w_bad        = req_is_bad(bus.req_size, bus.req_addr[1:0]);
    assign w_word_store = bus.req_we && (bus.req_size == SZ_WORD);

    always_comb begin
        w_state_next = r_state;
        w_idle       = 1'b0;
        w_mem_valid  = 1'b0;
        w_mem_rw     = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_idle = 1'b1;
                if (bus.req_valid) begin
                    if (w_bad)             w_state_next = RESP;
                    else if (w_word_store) w_state_next = WR;
                    else                   w_state_next = RD;
                end
            end
            RD: begin
                w_mem_valid  = 1'b1;
                w_state_next = CAP;
            end
            CAP: begin
                w_state_next = r_we ? WR : RESP;
            end
            WR: begin
                w_mem_valid  = 1'b1;
                w_mem_rw     = 1'b1;
                w_state_next = RESP;
            end
            RESP: begin
                w_rsp_valid  = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Everything after IDLE works from the latched request, never the live bus.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_we        <= 1'b0;
            r_signed    <= 1'b0;
            r_size      <= SZ_BYTE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_din       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we     <= bus.req_we;
                        r_signed <= bus.req_signed;
                        r_size   <= bus.req_size;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        if (w_bad) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else if (w_word_store) begin
                            r_din <= bus.req_wdata;
                        end
                    end
                end
                CAP: begin
                    if (r_we) begin
                        r_din <= w_merged;
                    end else begin
                        r_rsp_rdata <= w_load_data;
                        r_rsp_err   <= 1'b0;
                    end
                end
                WR: begin
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    byte_lane_unit u_lane (
        .i_size   (r_size),
        .i_offset (r_addr[1:0]),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .i_word   (mem_dout),
        .o_load   (w_load_data),
        .o_merged (w_merged)
    );

    assign bus.req_ready = w_idle && RESET;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    assign mem_addr  = r_addr[WIDTH+1:2];
    assign mem_din   = r_din;
    assign mem_rw    = w_mem_rw;
    assign mem_valid = w_mem_valid;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural word memory
// (registered read, write committed at the clock edge, active-high reset).
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic [WIDTH-1:0] mem_addr;
    logic [31:0]      mem_din;
    logic             mem_rw;
    logic             mem_valid;
    logic [31:0]      mem_dout;
    logic             mem_rst;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int mv_cnt = 0;
    int rsp_cnt = 0;
    int last_rd_cyc = 0;
    int last_wr_cyc = 0;

    mem_access_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mem_access_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_rw    (mem_rw),
        .mem_valid (mem_valid),
        .mem_dout  (mem_dout)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem_arr [0:(1<<WIDTH)-1];
    assign mem_rst = ~RESET;

    always @(posedge CLK) begin
        if (!mem_rst && mem_valid && mem_rw) mem_arr[mem_addr] <= mem_din;
    end

    always @(posedge CLK or posedge mem_rst) begin
        if (mem_rst) mem_dout <= '0;
        else if (mem_valid && !mem_rw) mem_dout <= mem_arr[mem_addr];
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (mem_valid) mv_cnt <= mv_cnt + 1;
        if (mem_valid && !mem_rw) begin
            rd_cnt      <= rd_cnt + 1;
            last_rd_cyc <= cyc;
        end
        if (mem_valid && mem_rw) begin
            wr_cnt      <= wr_cnt + 1;
            last_wr_cyc <= cyc;
        end
        if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [WIDTH+1:0] addr, input logic [31:0] wd);
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
    endtask

    // Present a request and wait for the accept edge; poisons the live inputs afterwards.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [WIDTH+1:0] addr, input logic [31:0] wd, input string tag);
        int n;
        @(negedge CLK);
        drive(we, size, sgn, addr, wd);
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_rdy"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_size   = SZ_ILL;
        bus.req_signed = ~sgn;
        bus.req_addr   = ~addr;
        bus.req_wdata  = ~wd;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [WIDTH+1:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                          input string tag);
        int n;
        issue(we, size, sgn, addr, wd, tag);
        n = 1;
        while (!bus.rsp_valid && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
        chk({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
        @(negedge CLK);
        chk({tag, "_pulse"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    // Reset k cycles after accepting a byte store to 0x04; nothing may reach memory or the core.
    task automatic abort_store(input int k, input string tag);
        int r0;
        int w0;
        r0 = rsp_cnt;
        w0 = wr_cnt;
        issue(1'b1, SZ_BYTE, 1'b0, 10'h004, 32'h000000AA, tag);
        repeat (k - 1) @(negedge CLK);
        chk({tag, "_mv_pre"}, {31'd0, mem_valid}, (k == 1) ? 32'd1 : 32'd0);
        RESET = 1'b0;
        #1;
        chk({tag, "_mv_rst"}, {31'd0, mem_valid}, 32'd0);
        chk({tag, "_rdy_rst"}, {31'd0, bus.req_ready}, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        repeat (4) @(negedge CLK);
        chk({tag, "_no_rsp"}, rsp_cnt - r0, 32'd0);
        chk({tag, "_no_wr"}, wr_cnt - w0, 32'd0);
        chk({tag, "_rdy_post"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    logic [31:0] b2b_exp [0:3];
    int          ready_cyc [0:3];

    initial begin
        int mv0;
        int rd0;
        int wr0;
        int r0;
        int acc;
        int got;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = SZ_BYTE;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        repeat (3) @(negedge CLK);
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        RESET = 1'b1;
        @(negedge CLK);
        chk("rel_ready", {31'd0, bus.req_ready}, 32'd1);

        do_req(1'b1, SZ_WORD, 1'b0, 10'h000, 32'hACBD4432, 2, 32'h0, 1'b0, "st_w0");
        do_req(1'b0, SZ_WORD, 1'b0, 10'h000, 32'h0, 3, 32'hACBD4432, 1'b0, "ld_w0");

        rd0 = rd_cnt;
        wr0 = wr_cnt;
        do_req(1'b1, SZ_BYTE, 1'b0, 10'h002, 32'h000000FF, 4, 32'h0, 1'b0, "st_b2");
        chk("st_b2_reads", rd_cnt - rd0, 32'd1);
        chk("st_b2_writes", wr_cnt - wr0, 32'd1);
        chk("st_b2_order", {31'd0, last_rd_cyc < last_wr_cyc}, 32'd1);
        do_req(1'b0, SZ_WORD, 1'b0, 10'h000, 32'h0, 3, 32'hACFF4432, 1'b0, "ld_w0b");

        do_req(1'b1, SZ_WORD, 1'b0, 10'h000, 32'hDFD6BB42, 2, 32'h0, 1'b0, "st_w0c");
        do_req(1'b0, SZ_HALF, 1'b1, 10'h002, 32'h0, 3, 32'hFFFFDFD6, 1'b0, "ld_hs2");
        do_req(1'b0, SZ_HALF, 1'b0, 10'h002, 32'h0, 3, 32'h0000DFD6, 1'b0, "ld_hu2");
        do_req(1'b0, SZ_BYTE, 1'b1, 10'h001, 32'h0, 3, 32'hFFFFFFBB, 1'b0, "ld_bs1");
        do_req(1'b1, SZ_HALF, 1'b0, 10'h002, 32'hFFFF1234, 4, 32'h0, 1'b0, "st_h2");
        do_req(1'b0, SZ_WORD, 1'b0, 10'h000, 32'h0, 3, 32'h1234BB42, 1'b0, "ld_w0d");
        do_req(1'b0, SZ_BYTE, 1'b0, 10'h003, 32'h0, 3, 32'h00000012, 1'b0, "ld_bu3");

        mv0 = mv_cnt;
        do_req(1'b0, SZ_WORD, 1'b0, 10'h006, 32'h0, 1, 32'h0, 1'b1, "ld_w_mis");
        do_req(1'b1, SZ_HALF, 1'b0, 10'h003, 32'h5555, 1, 32'h0, 1'b1, "st_h_mis");
        do_req(1'b0, SZ_ILL, 1'b0, 10'h000, 32'h0, 1, 32'h0, 1'b1, "ld_ill");
        chk("err_no_mem", mv_cnt - mv0, 32'd0);
        do_req(1'b0, SZ_WORD, 1'b0, 10'h000, 32'h0, 3, 32'h1234BB42, 1'b0, "ld_clr");

        do_req(1'b1, SZ_WORD, 1'b0, 10'h004, 32'h11223344, 2, 32'h0, 1'b0, "st_w4");
        abort_store(2, "ab_cap");
        do_req(1'b0, SZ_WORD, 1'b0, 10'h004, 32'h0, 3, 32'h11223344, 1'b0, "ld_w4a");
        abort_store(1, "ab_rd");
        do_req(1'b0, SZ_WORD, 1'b0, 10'h004, 32'h0, 3, 32'h11223344, 1'b0, "ld_w4b");

        do_req(1'b1, SZ_WORD, 1'b0, 10'h008, 32'hCAFEF00D, 2, 32'h0, 1'b0, "st_w8");
        do_req(1'b1, SZ_WORD, 1'b0, 10'h00C, 32'h5A5AA5A5, 2, 32'h0, 1'b0, "st_wc");

        b2b_exp[0] = 32'h1234BB42;
        b2b_exp[1] = 32'h11223344;
        b2b_exp[2] = 32'hCAFEF00D;
        b2b_exp[3] = 32'h5A5AA5A5;
        bus.req_we     = 1'b0;
        bus.req_size   = SZ_WORD;
        bus.req_signed = 1'b0;
        bus.req_wdata  = '0;
        r0  = rsp_cnt;
        acc = 0;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (bus.rsp_valid) begin
                if (got < 4) chk($sformatf("b2b_rdata%0d", got), bus.rsp_rdata, b2b_exp[got]);
                got++;
            end
            if (acc < 4) begin
                bus.req_addr  = 10'(acc * 4);
                bus.req_valid = 1'b1;
                if (bus.req_ready) begin
                    ready_cyc[acc] = c;
                    acc++;
                end
            end else begin
                bus.req_valid = 1'b0;
            end
            if (acc == 4 && got >= 4) break;
        end
        bus.req_valid = 1'b0;
        chk("b2b_accepts", acc, 32'd4);
        for (int i = 1; i < 4; i++) begin
            if (i < acc) chk($sformatf("b2b_gap%0d", i), ready_cyc[i] - ready_cyc[i-1], 32'd4);
        end
        repeat (6) @(negedge CLK);
        chk("b2b_rsp_total", rsp_cnt - r0, 32'd4);
        chk("b2b_seen", got, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
